// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding and
// default widths/values used by fetch_ctrl and ifid_buf.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT      = 32;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // REQ: may issue; WAIT: live request outstanding; DRAIN: killed request outstanding
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_ifid_buf.sv
// One-entry IF/ID register slice. Flush beats load, load beats drain, so an
// entry can be handed to decode and replaced on the same edge.
module ifid_buf
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic            drain,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic            load_misaligned,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            misaligned
);

    // Entry register: empty or flushed slots present NOP_INSTR to decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            instr      <= NOP_INSTR;
            pc         <= '0;
            misaligned <= 1'b0;
        end else if (flush) begin
            valid      <= 1'b0;
            instr      <= NOP_INSTR;
            misaligned <= 1'b0;
        end else if (load) begin
            valid      <= 1'b1;
            instr      <= load_instr;
            pc         <= load_pc;
            misaligned <= load_misaligned;
        end else if (drain) begin
            valid      <= 1'b0;
            instr      <= NOP_INSTR;
            misaligned <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, PC-next muxing
// toward pc_reg, EX redirects that kill in-flight requests, and a one-entry
// IF/ID buffer toward decode.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to turn a misaligned PC into
// a fault entry instead of a memory request.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            pc_write_en_o,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            ifid_valid_o,
    output logic [XLEN-1:0] ifid_instr_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic            ifid_misaligned_o,
    input  logic            ifid_ready_i
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] req_pc;
    logic            fault_hold;
    logic            fault_set;
    logic            req_fire;
    logic            buf_free;
    logic            buf_drain;
    logic            buf_load;
    logic            buf_flush;
    logic [XLEN-1:0] buf_load_instr;
    logic [XLEN-1:0] buf_load_pc;
    logic            buf_load_mis;
    logic            pc_misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign pc_misaligned = (pc_i[1:0] != 2'b00);
`else
    assign pc_misaligned = 1'b0;
`endif

    assign buf_free        = !ifid_valid_o || ifid_ready_i;
    assign buf_drain       = ifid_valid_o && ifid_ready_i;
    assign imem_req_addr_o = pc_i;

    // Next-state, PC-next mux, request issue and buffer load/flush decisions
    always_comb begin
        state_next       = state;
        pc_next_o        = pc_i + XLEN'(4);
        pc_write_en_o    = 1'b0;
        imem_req_valid_o = 1'b0;
        req_fire         = 1'b0;
        fault_set        = 1'b0;
        buf_flush        = 1'b0;
        buf_load         = 1'b0;
        buf_load_instr   = imem_rsp_data_i;
        buf_load_pc      = req_pc;
        buf_load_mis     = 1'b0;

        if (redirect_i) begin
            pc_next_o     = redirect_target_i;
            pc_write_en_o = 1'b1;
            buf_flush     = 1'b1;
            unique case (state)
                ST_WAIT:  state_next = imem_rsp_valid_i ? ST_REQ : ST_DRAIN;
                ST_DRAIN: state_next = imem_rsp_valid_i ? ST_REQ : ST_DRAIN;
                default:  state_next = ST_REQ;
            endcase
        end else begin
            unique case (state)
                ST_REQ: begin
                    if (buf_free && !fault_hold) begin
                        if (pc_misaligned) begin
                            buf_load       = 1'b1;
                            buf_load_instr = NOP_INSTR;
                            buf_load_pc    = pc_i;
                            buf_load_mis   = 1'b1;
                            fault_set      = 1'b1;
                        end else begin
                            imem_req_valid_o = 1'b1;
                            if (imem_req_ready_i) begin
                                req_fire      = 1'b1;
                                pc_write_en_o = 1'b1;
                                state_next    = ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        buf_load   = 1'b1;
                        state_next = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rsp_valid_i) state_next = ST_REQ;
                end
                default: state_next = ST_REQ;
            endcase
        end

        // Combinational outputs stay quiet while reset is asserted
        if (!rst_n) begin
            imem_req_valid_o = 1'b0;
            pc_write_en_o    = 1'b0;
        end
    end

    // State register, PC of the live request, and sticky misaligned-fault hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_REQ;
            req_pc     <= '0;
            fault_hold <= 1'b0;
        end else begin
            state <= state_next;
            if (req_fire) req_pc <= pc_i;
            if (redirect_i)     fault_hold <= 1'b0;
            else if (fault_set) fault_hold <= 1'b1;
        end
    end

    ifid_buf #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_buf (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (buf_flush),
        .load            (buf_load),
        .drain           (buf_drain),
        .load_instr      (buf_load_instr),
        .load_pc         (buf_load_pc),
        .load_misaligned (buf_load_mis),
        .valid           (ifid_valid_o),
        .instr           (ifid_instr_o),
        .pc              (ifid_pc_o),
        .misaligned      (ifid_misaligned_o)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: live pc_reg and variable-latency memory, with a
// program-stream reference model (expected fetch address, outstanding/killed
// request, expected IF/ID entry) checked every cycle.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] pc_next_o;
    logic        pc_write_en_o;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic        ifid_misaligned_o;
    logic        ifid_ready_i;

    fetch_ctrl #(
        .XLEN      (32),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_i              (pc_i),
        .pc_next_o         (pc_next_o),
        .pc_write_en_o     (pc_write_en_o),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_rsp_valid_i  (imem_rsp_valid_i),
        .imem_rsp_data_i   (imem_rsp_data_i),
        .ifid_valid_o      (ifid_valid_o),
        .ifid_instr_o      (ifid_instr_o),
        .ifid_pc_o         (ifid_pc_o),
        .ifid_misaligned_o (ifid_misaligned_o),
        .ifid_ready_i      (ifid_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // environment: pc_reg and memory
    logic [31:0] pc_q;
    bit          mem_busy;
    int unsigned mem_cnt;
    logic [31:0] mem_addr;

    // reference model
    bit          m_valid, m_mis, m_fault, m_out, m_killed;
    logic [31:0] m_pc, m_instr, m_fetch, m_addr;

    // knobs
    bit          k_redirect, k_req_ready, k_ifid_ready;
    logic [31:0] k_target;
    int unsigned k_lat;

    // samples and logs
    bit          s_req_valid, s_we, s_ifid_valid, s_mis;
    logic [31:0] s_addr, s_next, s_ifid_pc, s_ifid_instr;
    logic [31:0] hs_q[$];
    logic [31:0] dl_pc[$];
    logic [31:0] dl_instr[$];
    int          dl_cyc[$];
    int          cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        bit          m_free, mis_now, exp_req, rsp;
        redirect_i        = k_redirect;
        redirect_target_i = k_target;
        imem_req_ready_i  = k_req_ready;
        ifid_ready_i      = k_ifid_ready;
        pc_i              = pc_q;
        imem_rsp_valid_i  = mem_busy && (mem_cnt == 0);
        imem_rsp_data_i   = imem_rsp_valid_i ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        #2;
        s_req_valid  = imem_req_valid_o;
        s_addr       = imem_req_addr_o;
        s_we         = pc_write_en_o;
        s_next       = pc_next_o;
        s_ifid_valid = ifid_valid_o;
        s_ifid_pc    = ifid_pc_o;
        s_ifid_instr = ifid_instr_o;
        s_mis        = ifid_misaligned_o;

        m_free  = !m_valid || k_ifid_ready;
        mis_now = MIS_EN && (m_fetch[1:0] != 2'b00);
        exp_req = !m_out && m_free && !k_redirect && !mis_now && !m_fault;
        check("req_valid", 32'(s_req_valid), 32'(exp_req));
        if (exp_req) check("req_addr", s_addr, m_fetch);
        check("pc_we", 32'(s_we), 32'(k_redirect || (exp_req && k_req_ready)));
        check("pc_next", s_next, k_redirect ? k_target : pc_q + 32'd4);
        check("ifid_valid", 32'(s_ifid_valid), 32'(m_valid));
        if (m_valid) begin
            check("ifid_pc", s_ifid_pc, m_pc);
            check("ifid_instr", s_ifid_instr, m_instr);
            check("ifid_mis", 32'(s_mis), 32'(m_mis));
        end else begin
            check("ifid_nop", s_ifid_instr, NOP);
        end

        if (s_req_valid && k_req_ready) hs_q.push_back(s_addr);
        if (s_ifid_valid && k_ifid_ready) begin
            dl_pc.push_back(s_ifid_pc);
            dl_instr.push_back(s_ifid_instr);
            dl_cyc.push_back(cyc);
        end

        rsp = imem_rsp_valid_i;
        if (m_valid && k_ifid_ready) m_valid = 1'b0;
        if (k_redirect) begin
            m_valid = 1'b0;
            m_fault = 1'b0;
            if (m_out) begin
                if (rsp) begin
                    m_out    = 1'b0;
                    m_killed = 1'b0;
                end else begin
                    m_killed = 1'b1;
                end
            end
            m_fetch = k_target;
        end else if (rsp && m_out) begin
            if (!m_killed) begin
                m_valid = 1'b1;
                m_pc    = m_addr;
                m_instr = mem_word(m_addr);
                m_mis   = 1'b0;
            end
            m_out    = 1'b0;
            m_killed = 1'b0;
        end else if (exp_req && k_req_ready) begin
            m_out   = 1'b1;
            m_addr  = m_fetch;
            m_fetch = m_fetch + 32'd4;
        end else if (!m_out && m_free && mis_now && !m_fault) begin
            m_valid = 1'b1;
            m_pc    = m_fetch;
            m_instr = NOP;
            m_mis   = 1'b1;
            m_fault = 1'b1;
        end

        if (s_we) pc_q = s_next;
        if (rsp) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt = mem_cnt - 1;
        if (s_req_valid && k_req_ready) begin
            mem_busy = 1'b1;
            mem_cnt  = k_lat - 1;
            mem_addr = s_addr;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_i = 1'b0; redirect_target_i = '0; imem_req_ready_i = 1'b0;
        ifid_ready_i = 1'b1; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        pc_q = '0; pc_i = '0; mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
        m_valid = 1'b0; m_mis = 1'b0; m_fault = 1'b0; m_out = 1'b0; m_killed = 1'b0;
        m_pc = '0; m_instr = NOP; m_fetch = '0; m_addr = '0;
        #2;
        check("rst_ifid_valid", 32'(ifid_valid_o), 32'd0);
        check("rst_ifid_instr", ifid_instr_o, NOP);
        check("rst_ifid_pc", ifid_pc_o, 32'd0);
        check("rst_ifid_mis", 32'(ifid_misaligned_o), 32'd0);
        check("rst_pc_we", 32'(pc_write_en_o), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        rst_n = 1'b1;
        k_redirect = 1'b0; k_target = '0; k_req_ready = 1'b1; k_ifid_ready = 1'b1; k_lat = 1;
        #1;
        do_reset();

        // sequential fetch, 1-cycle memory
        repeat (6) cycle();
        check("seq_hs_count", 32'(hs_q.size()), 32'd3);
        if (hs_q.size() >= 3) begin
            check("seq_hs0", hs_q[0], 32'h0);
            check("seq_hs1", hs_q[1], 32'h4);
            check("seq_hs2", hs_q[2], 32'h8);
        end
        check("seq_dl_count", 32'(dl_pc.size()), 32'd2);
        if (dl_pc.size() >= 2) begin
            check("seq_dl0_pc", dl_pc[0], 32'h0);
            check("seq_dl0_instr", dl_instr[0], mem_word(32'h0));
            check("seq_dl1_pc", dl_pc[1], 32'h4);
            check("seq_rate", 32'(dl_cyc[1] - dl_cyc[0]), 32'd2);
        end

        // decode stall with entry at 0x8
        k_ifid_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("stall_valid", 32'(s_ifid_valid), 32'd1);
            check("stall_pc", s_ifid_pc, 32'h8);
            check("stall_req", 32'(s_req_valid), 32'd0);
            check("stall_we", 32'(s_we), 32'd0);
        end
        k_ifid_ready = 1'b1;
        k_lat = 3;
        n = hs_q.size();
        cycle();
        check("resume_hs", 32'(hs_q.size()), 32'(n + 1));
        if (hs_q.size() > n) check("resume_addr", hs_q[n], 32'hC);
        check("resume_dl_pc", dl_pc[dl_pc.size()-1], 32'h8);

        // redirect while WAIT (latency 3) to 0x100
        k_redirect = 1'b1; k_target = 32'h100;
        cycle();
        k_redirect = 1'b0;
        cycle();
        check("redir_flush", 32'(s_ifid_valid), 32'd0);
        n = hs_q.size();
        for (int i = 0; i < 20 && hs_q.size() == n; i++) cycle();
        check("redir_hs_seen", 32'(hs_q.size() > n), 32'd1);
        if (hs_q.size() > n) check("redir_addr", hs_q[n], 32'h100);
        n = dl_pc.size();
        for (int i = 0; i < 20 && dl_pc.size() == n; i++) cycle();
        check("redir_dl_seen", 32'(dl_pc.size() > n), 32'd1);
        if (dl_pc.size() > n) check("redir_dl_pc", dl_pc[n], 32'h100);

        // redirect coincident with a response in WAIT
        k_lat = 2;
        for (int i = 0; i < 20 && !(m_out && mem_busy && mem_cnt == 0); i++) cycle();
        check("coinc_setup", 32'(m_out && mem_busy && mem_cnt == 0), 32'd1);
        k_redirect = 1'b1; k_target = 32'h200;
        cycle();
        k_redirect = 1'b0;
        cycle();
        check("coinc_req", 32'(s_req_valid), 32'd1);
        check("coinc_addr", s_addr, 32'h200);

        // memory backpressure
        for (int i = 0; i < 20 && m_out; i++) cycle();
        k_req_ready = 1'b0;
        repeat (4) begin
            cycle();
            check("bp_req", 32'(s_req_valid), 32'd1);
            check("bp_addr", s_addr, 32'h204);
            check("bp_we", 32'(s_we), 32'd0);
        end
        k_req_ready = 1'b1;
        cycle();
        check("bp_release_we", 32'(s_we), 32'd1);

        // reset asserted mid-request
        k_lat = 3;
        cycle();
        do_reset();
        k_lat = 1;
        repeat (8) cycle();

        // randomized traffic
        repeat (400) begin
            k_ifid_ready = ($urandom_range(0, 9) < 7);
            k_req_ready  = ($urandom_range(0, 9) < 6);
            k_redirect   = ($urandom_range(0, 99) < 8);
            k_target     = 32'($urandom_range(0, 1023)) << 2;
            k_lat        = $urandom_range(1, 4);
            cycle();
        end
        k_redirect = 1'b0; k_ifid_ready = 1'b1; k_req_ready = 1'b1;

`ifdef FETCH_MISALIGN_CHECK_EN
        // misaligned redirect target produces a fault entry, no request
        for (int i = 0; i < 20 && m_out; i++) cycle();
        k_redirect = 1'b1; k_target = 32'h102;
        cycle();
        k_redirect = 1'b0;
        n = hs_q.size();
        repeat (2) cycle();
        check("mis_valid", 32'(s_ifid_valid), 32'd1);
        check("mis_flag", 32'(s_mis), 32'd1);
        check("mis_pc", s_ifid_pc, 32'h102);
        repeat (3) cycle();
        check("mis_no_req", 32'(hs_q.size()), 32'(n));
        k_redirect = 1'b1; k_target = 32'h200;
        cycle();
        k_redirect = 1'b0;
        for (int i = 0; i < 20 && hs_q.size() == n; i++) cycle();
        check("mis_recover", 32'(hs_q.size() > n), 32'd1);
        if (hs_q.size() > n) check("mis_recover_addr", hs_q[n], 32'h200);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that drives the PC register's `pc_next_i`/`pc_write_en_i` and consumes its `pc_o`. It issues one instruction-memory request at a time over a valid/ready channel and captures the response into a one-entry IF/ID buffer with a valid/ready handshake toward decode. Branch and jump redirects from EX override sequential fetch and kill any in-flight request. It sits between `pc_reg`, instruction memory and the decode stage.

## Interface
- `XLEN`, 32, address/instruction width
- `NOP_INSTR`, 32'h0000_0013, value driven on `ifid_instr_o` when the buffer is empty or flushed
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pc_i`  in  XLEN  current PC from `pc_reg.pc_o`
- `pc_next_o`  out  XLEN  to `pc_reg.pc_next_i`
- `pc_write_en_o`  out  1  to `pc_reg.pc_write_en_i`
- `redirect_i`  in  1  branch/jump taken (EX stage)
- `redirect_target_i`  in  XLEN  redirect target address
- `imem_req_valid_o`  out  1  fetch request valid
- `imem_req_addr_o`  out  XLEN  fetch address
- `imem_req_ready_i`  in  1  memory accepts request
- `imem_rsp_valid_i`  in  1  response valid (one per accepted request, ≥1 cycle later)
- `imem_rsp_data_i`  in  XLEN  fetched instruction
- `ifid_valid_o`  out  1  buffered instruction valid
- `ifid_instr_o`  out  XLEN  buffered instruction
- `ifid_pc_o`  out  XLEN  PC of buffered instruction
- `ifid_misaligned_o`  out  1  buffered entry is a misaligned-fetch fault
- `ifid_ready_i`  in  1  decode accepts the buffered entry

## Operation
- FSM states:
  - REQ: may issue.
  - WAIT: one request outstanding.
  - DRAIN: one killed request outstanding.
- Buffer is "free" when `!ifid_valid_o || ifid_ready_i`.
- REQ:
  - `imem_req_valid_o = buf_free && !redirect_i`, with `imem_req_addr_o = pc_i`.
  - On handshake: latch `req_pc = pc_i`, `pc_write_en_o = 1`, `pc_next_o = pc_i + 4` (mod 2^XLEN, wrap silently), then go to WAIT.
- WAIT:
  - On `imem_rsp_valid_i`: buffer loads {`imem_rsp_data_i`, `req_pc`}, `ifid_valid_o` is set, then go to REQ.
- DRAIN:
  - On `imem_rsp_valid_i`: response is discarded, then go to REQ.
- Redirect (highest priority, any state):
  - `pc_next_o = redirect_target_i`, `pc_write_en_o = 1`.
  - Buffer is flushed: `ifid_valid_o` goes to 0 and instr goes to `NOP_INSTR`.
  - No request is issued in that cycle. This is the only case where `imem_req_valid_o` may drop without a handshake.
  - In WAIT without `imem_rsp_valid_i`: go to DRAIN.
  - In WAIT with `imem_rsp_valid_i` in the same cycle: drop the response and go to REQ.
  - In DRAIN: stay in DRAIN; if `imem_rsp_valid_i` is also high, drop it and go to REQ.
  - In REQ: stay in REQ.
- Otherwise `pc_write_en_o = 0` and `pc_next_o = pc_i + 4`. A decode stall (`ifid_ready_i = 0` with a valid entry) therefore freezes the PC.
- Buffer holds its entry until `ifid_valid_o && ifid_ready_i`. It may be drained and reloaded in the same cycle.

## Timing
- Reset values: state REQ, kill cleared, `ifid_valid_o = 0`, `ifid_instr_o = NOP_INSTR`, `ifid_pc_o = 0`, `ifid_misaligned_o = 0`, `pc_write_en_o = 0`, `imem_req_valid_o = 0`.
- Reset asserted mid-request: the outstanding response is ignored after reset deassertion. The memory must also be reset.
- `pc_next_o`, `pc_write_en_o` and `imem_req_*` are combinational from state, `redirect_i`, `imem_req_ready_i` and `ifid_ready_i`. All other outputs are registered.
- Latency: handshake at cycle t; response at t+k; `ifid_valid_o` high at t+k+1.
- With a 1-cycle memory and decode always ready, throughput is one instruction per 2 cycles.
- The PC register updates at the same edge that completes the handshake, so `pc_i` equals the old PC + 4 at t+1.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - In REQ with `pc_i[1:0] != 0` and the buffer free, no memory request is issued.
  - The buffer loads {`NOP_INSTR`, `pc_i`} with `ifid_misaligned_o = 1`.
  - The PC is not advanced. The FSM stays in REQ until a redirect, and no further entries are produced.
- Not defined: `ifid_misaligned_o` is tied 0 and every address is issued unmodified.

## Structure
- Package `fetch_pkg`: FSM state encoding (REQ/WAIT/DRAIN), `NOP_INSTR` default, `XLEN` default.
- Sub-module `ifid_buf`: one-entry register slice with load, drain, flush and misaligned flag. It is instantiated once.
- FSM and PC-next muxing live in `fetch_ctrl`.

## Test plan
- Sequential fetch, 1-cycle memory, `pc_i` from a live `pc_reg` starting at 0x0:
  - Requests go to 0x0, 0x4, 0x8.
  - IF/ID delivers {instr, pc} = {mem[0x0], 0x0}, {mem[0x4], 0x4}, {mem[0x8], 0x8} at the 2-cycle rate.
- Decode stall: hold `ifid_ready_i = 0` for 3 cycles with an entry at PC 0x8:
  - `ifid_pc_o` stays 0x8.
  - No new request is issued.
  - `pc_write_en_o` stays 0.
  - Fetching resumes at 0xC after release.
- Redirect while WAIT (memory latency 3), target 0x100:
  - The pending response is dropped.
  - `ifid_valid_o` is 0 the next cycle.
  - The next request goes to 0x100.
  - The first IF/ID entry has PC 0x100.
- Redirect coincident with `imem_rsp_valid_i` in WAIT:
  - The response is discarded.
  - The FSM is in REQ next cycle, with no DRAIN.
- Memory backpressure: `imem_req_ready_i = 0` for 4 cycles:
  - `imem_req_valid_o` stays 1 with address stable.
  - `pc_write_en_o` stays 0 until the handshake.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x102:
  - `ifid_valid_o = 1`, `ifid_misaligned_o = 1`, `ifid_pc_o = 0x102`.
  - No memory request is issued.
  - A redirect to 0x200 then recovers fetching.
